// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key schedule controller.
//   NR        : number of AES-128 rounds (round keys 0..NR are stored)
//   state_e   : controller FSM states
//   RconPoly  : GF(2^8) reduction constant used when doubling rcon
//   xtime()   : multiply a byte by x in GF(2^8)
package aes_pkg;

  localparam int unsigned NR       = 10;
  localparam int unsigned NumRk    = NR + 1;
  localparam logic [3:0]  LastRnd  = 4'(NR);
  localparam logic [7:0]  RconInit = 8'h01;
  localparam logic [7:0]  RconPoly = 8'h1b;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StDone
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RconPoly : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rk_store.sv
// Round-key register file: 11 x 128-bit entries, one write port, one registered read port.
//   clk, rst_n : clock and asynchronous active-low reset (read register only)
//   wr_en      : write rk[wr_idx] <= wr_data at the rising edge
//   wr_idx     : write index, 0..10
//   wr_data    : round key to store
//   rd_idx     : read index; values above 10 read as zero
//   rd_key     : registered read data, 1-cycle latency
module aes_rk_store
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [3:0]   wr_idx,
  input  logic [127:0] wr_data,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  // Storage is deliberately left without reset; keys_valid qualifies its contents.
  logic [127:0] rk_q [NumRk];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      rk_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_key <= '0;
    end else if (rd_idx <= LastRnd) begin
      rd_key <= rk_q[rd_idx];
    end else begin
      rd_key <= '0;
    end
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller. Sequences an external combinational round-key expander
// through rounds 1..10, storing every round key in aes_rk_store.
//   clk, rst_n         : clock and asynchronous active-low reset
//   start, key_in      : expansion request and cipher key (sampled when start is accepted)
//   busy, done         : run in progress / one-cycle completion pulse
//   keys_valid         : round keys 0..10 are complete and coherent
//   exp_in, exp_rcon   : registered word set and round constant to the expander
//   exp_out            : expander result, valid one cycle after exp_in/exp_rcon change
//   rd_idx, rd_key     : round-key read port, 1-cycle latency, zero above index 10
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic [127:0] exp_in,
  output logic [7:0]   exp_rcon,
  input  logic [127:0] exp_out,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
);

  state_e       state;
  logic [3:0]   rnd;
  logic [7:0]   rcon;

  logic         rk_wr_en;
  logic [3:0]   rk_wr_idx;
  logic [127:0] rk_wr_data;

  // exp_in doubles as the working word set: it is only reloaded when a new round is issued,
  // so it holds its last value through DONE and IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      rnd        <= '0;
      rcon       <= RconInit;
      exp_in     <= '0;
      exp_rcon   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            state      <= StIssue;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
            rnd        <= 4'd1;
            rcon       <= RconInit;
            exp_in     <= key_in;
            exp_rcon   <= RconInit;
          end
        end
        StIssue: begin
          state <= StCapture;
        end
        StCapture: begin
          rcon <= xtime(rcon);
          if (rnd == LastRnd) begin
            state      <= StDone;
            done       <= 1'b1;
            keys_valid <= 1'b1;
          end else begin
            state    <= StIssue;
            rnd      <= rnd + 4'd1;
            exp_in   <= exp_out;
            exp_rcon <= xtime(rcon);
          end
        end
        StDone: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // rk[0] is written with the accepted key; rk[rnd] with the expander result in CAPTURE.
  always_comb begin
    rk_wr_en   = 1'b0;
    rk_wr_idx  = '0;
    rk_wr_data = exp_out;
    if (state == StIdle && start) begin
      rk_wr_en   = 1'b1;
      rk_wr_idx  = '0;
      rk_wr_data = key_in;
    end else if (state == StCapture) begin
      rk_wr_en   = 1'b1;
      rk_wr_idx  = rnd;
      rk_wr_data = exp_out;
    end
  end

  aes_rk_store u_rk_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rk_wr_en),
    .wr_idx  (rk_wr_idx),
    .wr_data (rk_wr_data),
    .rd_idx  (rd_idx),
    .rd_key  (rd_key)
  );

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; all ports are listed below as name, direction, width, meaning.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  asynchronous reset, active low.
REQ-004 start  in  1  single-cycle request to expand key_in; SHALL be ignored while busy=1.
REQ-005 key_in  in  128  cipher key {w0,w1,w2,w3}, MSB = w0[31]; sampled only in the cycle start is accepted.
REQ-006 busy  out  1  high from the cycle after start is accepted through the DONE state.
REQ-007 done  out  1  one-cycle pulse when all 11 round keys are stored.
REQ-008 keys_valid  out  1  stored round keys 0..10 are complete and coherent.
REQ-009 exp_in  out  128  key word set driven to the external round-key expander (1-cycle in->out_2 path).
REQ-010 exp_rcon  out  8  round constant driven to the expander.
REQ-011 exp_out  in  128  expander combinational output, valid 1 cycle after exp_in/exp_rcon are applied.
REQ-012 rd_idx  in  4  round-key read index, 0..10.
REQ-013 rd_key  out  128  round key rd_idx, registered with 1-cycle latency.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, CAPTURE and DONE.
REQ-015 IDLE->ISSUE on start=1: rk[0]<=key_in, cur<=key_in, rnd<=1, rcon<=8'h01, keys_valid<=0.
REQ-016 ISSUE->CAPTURE unconditionally; exp_in=cur and exp_rcon=rcon SHALL be held stable across ISSUE.
REQ-017 CAPTURE: rk[rnd]<=exp_out and cur<=exp_out; rcon<=xtime(rcon), where xtime = {rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00).
REQ-018 CAPTURE with rnd==10 SHALL go to DONE; otherwise rnd<=rnd+1 and go to ISSUE.
REQ-019 The rcon sequence SHALL be 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
REQ-020 DONE: done=1 and keys_valid<=1 for one cycle, then IDLE.
REQ-021 Timing: if start is sampled at edge E0, round k SHALL be captured at edge E(2k), and done SHALL be high in the cycle after edge E20.
REQ-022 exp_in and exp_rcon SHALL be registered outputs; in IDLE and DONE they SHALL hold their last values.
REQ-023 start in the DONE cycle SHALL be ignored; start in IDLE with keys_valid=1 SHALL begin a new run and clear keys_valid.
REQ-024 rd_key SHALL return rk[rd_idx] one cycle after rd_idx, for any state.
REQ-025 rd_idx>10 SHALL return 128'h0.
REQ-026 Reads while keys_valid=0 SHALL return the current storage contents, which are undefined mixtures; this is not an error.

Reset
REQ-027 rst_n=0 SHALL, asynchronously: state=IDLE, busy=0, done=0, keys_valid=0, rnd=0, rcon=8'h01, exp_in=0, exp_rcon=0, rd_key=0.
REQ-028 Round-key storage SHALL NOT require reset.
REQ-029 Reset asserted mid-expansion SHALL abort the run; after release, a new start is required before keys_valid can rise.

Structure
REQ-030 Shared package aes_pkg SHALL hold NR=10, the FSM state enum, the xtime function and the rcon reduction constant 8'h1b.
REQ-031 The 11x128 round-key register file with its registered read port SHALL be the sub-module aes_rk_store.
REQ-032 The expander SHALL stay outside this module, connected through the exp_* ports.

Verification
REQ-033 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> rk[1]=a0fafe1788542cb123a339392a6c7605 and rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6; done exactly 20 cycles after the start edge.
REQ-034 Monitor exp_rcon during ISSUE cycles -> 01,02,04,08,10,20,40,80,1b,36 in order, each held for 2 cycles.
REQ-035 start pulsed in mid-run round 4 with a different key_in -> ignored; final keys match the first key.
REQ-036 rst_n low during round 6 -> busy=0 and keys_valid=0 immediately; a new start with key 000..0 -> rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-037 Back-to-back start asserted in the DONE cycle, then in IDLE -> the first is ignored, the second runs, and keys_valid drops then re-rises.
REQ-038 rd_idx=0..15 swept after done -> rk[0..10] returned with 1-cycle latency, and zero for indices 11..15.
